signal_watchdog_mc: RTL and testbench
=====================================

Name: signal_watchdog_mc

Overview:
Multi-channel, parametrised receiver watchdog for the OFDM RX front end. It tracks, per antenna channel, the running sum of I and Q sign bits over a 2^LOG2_SUM_LEN window to detect DC/saturated or stuck input. It also checks the decoded SIGNAL length, debounces faults through an FSM, and issues a timed receiver_rst pulse followed by a hold-off. It supersedes the single-channel watchdog and adds channel masking, any/all combining, debounce, hold-off, a window flush on trip, trip-cause reporting and a trip counter.

Parameters:
IQ_DATA_WIDTH, 16, bits per I or Q sample
NUM_CH, 2, number of antenna channels
LOG2_SUM_LEN, 6, log2 of window length W
MIN_SIGNAL_LEN, 14, smallest legal SIGNAL length
RST_PULSE_LEN, 4, receiver_rst pulse width in cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
enable  in  1  0 = watchdog idle, no resets issued
iq_data  in  NUM_CH*2*IQ_DATA_WIDTH  per channel c: {Q,I} at [c*2*IQ_DATA_WIDTH +: 2*IQ_DATA_WIDTH], I in low half, signed
iq_valid  in  1  one sample per channel valid this cycle
ch_mask  in  NUM_CH  1 = channel participates
combine_all  in  1  0 = trip when any masked channel hits; 1 = trip only when all masked channels hit
signal_len  in  16  decoded SIGNAL length
sig_valid  in  1  signal_len valid (single-cycle strobe)
max_signal_len_th  in  16  largest legal length
dc_running_sum_th  in  LOG2_SUM_LEN+1  unsigned threshold on |sum|
debounce_th  in  8  consecutive DC-hit samples required; 0 treated as 1
holdoff_len  in  16  cycles after pulse during which no new trip is accepted
receiver_rst  out  1  registered reset request to the RX chain
trip_cause  out  2  01 DC, 10 length, 11 both; held until next trip
dc_flag  out  NUM_CH  registered per-channel DC hit (masked)
window_full  out  1  all windows have held W samples since last flush
trip_count  out  16  saturating count of trips

Behaviour:
- Reset (async, rst=1): state ARMED; all outputs 0; sums, fill counter, sign history and debounce counter 0.
- Sign mapping: MSB=1 gives -1, else +1; a zero sample counts as +1.
- Per stream (2*NUM_CH streams): sum over the last min(n,W) valid samples. Width LOG2_SUM_LEN+2 signed, range -W..+W.
- Sum update on iq_valid: new sign is added. The sign leaving the window is subtracted only when fill==W. The shared fill counter saturates at W; window_full = (fill==W).
- hit[c] = window_full & (|sumI|>=th | |sumQ|>=th). With th=0, every channel hits once the window is full.
- dc_flag[c] <= hit[c] & ch_mask[c], one cycle after the sum register updates.
- dc_cond: combine_all=0 gives |dc_flag. combine_all=1 gives (ch_mask!=0) & all masked dc_flag set. ch_mask=0 means dc_cond is never true.
- len_fault = sig_valid & (signal_len<MIN_SIGNAL_LEN | signal_len>max_signal_len_th), sampled at the clock edge.
- FSM, states ARMED, FIRE, HOLDOFF:
  - ARMED, iq_valid & dc_cond: deb_cnt++. iq_valid & !dc_cond: deb_cnt<=0. Non-valid cycles hold deb_cnt.
  - ARMED exits to FIRE when len_fault, or when (iq_valid & dc_cond & deb_cnt+1>=max(debounce_th,1)).
  - On FIRE entry: trip_cause is set from both conditions in that cycle (simultaneous gives 11). trip_count increments, saturating at 0xFFFF. deb_cnt<=0. All sums, history and fill are flushed to 0.
  - FIRE: receiver_rst=1 for exactly RST_PULSE_LEN cycles, then HOLDOFF.
  - HOLDOFF: count holdoff_len cycles (0 means exit next cycle), then ARMED. len_fault and dc_cond are ignored. Sums keep accumulating but cannot trip.
- Latency: a trip-qualifying edge k puts receiver_rst high in cycle k+1; no combinational path from inputs to receiver_rst.
- enable=0, from any state: next edge to ARMED; receiver_rst, deb_cnt and timers clear. Sums keep running. trip_count and trip_cause hold.
- A flush coincident with iq_valid discards that sample; the window restarts empty.

Decomposition:
- Package signal_watchdog_pkg: FSM state enum, trip_cause encodings (CAUSE_DC, CAUSE_LEN), and the sum-width function LOG2_SUM_LEN+2.
- Sub-module sign_window_sum: one stream with a W-deep sign-bit history (shift register), running sum and flush input; generated 2*NUM_CH times. The fill counter stays in the top level.

Test Plan:
- NUM_CH=2, L=6, th=40, debounce_th=1, mask=11, combine_all=0. Ch0 I constant +100, other streams alternating sign, 64 valids. dc_flag=01 after the 64th sample; receiver_rst high 4 cycles; trip_cause=01; trip_count=1; window_full drops to 0.
- Same stimulus with combine_all=1: no trip. Then make ch1 Q constant negative: trip once both flags are set.
- debounce_th=5, DC hit for 4 valids, 1 clean valid, then 5 hits: trip occurs only after the final 5th consecutive hit.
- sig_valid with signal_len=13, then 14, then max_signal_len_th+1: trips at 13 and at max+1, none at 14. The max+1 case is tested after holdoff expires; trip_cause=10.
- holdoff_len=100, len_fault at 50 cycles into HOLDOFF: ignored. The same fault at cycle 101 after holdoff start trips. A simultaneous DC and length trip gives trip_cause=11.
- Assert rst mid-FIRE: receiver_rst drops immediately (async), all outputs 0. Separately, enable=0 mid-HOLDOFF returns to ARMED next edge with counters held.

Source files
------------

// File: rtl/signal_watchdog_pkg.sv
// Shared types and helpers for the multi-channel receiver watchdog.
package signal_watchdog_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } wd_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_DC   = 2'b01;
    localparam logic [1:0] CAUSE_LEN  = 2'b10;

    // Signed running-sum width able to hold -W..+W for W = 2**log2_sum_len.
    function automatic int unsigned sum_width(input int unsigned log2_sum_len);
        return log2_sum_len + 2;
    endfunction

endpackage

// File: rtl/sign_window_sum.sv
// Running sum of +1/-1 sign values over the last W valid samples of one stream.
module sign_window_sum
    import signal_watchdog_pkg::*;
#(
    parameter int unsigned LOG2_SUM_LEN = 6
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       sample_valid,
    input  logic                                       sign_neg,
    input  logic                                       window_full,
    input  logic                                       flush,
    output logic signed [sum_width(LOG2_SUM_LEN)-1:0]  sum
);

    localparam int unsigned W  = 1 << LOG2_SUM_LEN;
    localparam int unsigned SW = sum_width(LOG2_SUM_LEN);

    logic [W-1:0]          hist;
    logic signed [SW-1:0]  add_term;
    logic signed [SW-1:0]  sub_term;

    // Oldest sign leaves the window only once the window is full.
    always_comb begin
        add_term = sign_neg ? {SW{1'b1}} : SW'(1);
        sub_term = '0;
        if (window_full)
            sub_term = hist[W-1] ? {SW{1'b1}} : SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            sum  <= '0;
        end else if (flush) begin
            hist <= '0;
            sum  <= '0;
        end else if (sample_valid) begin
            hist <= {hist[W-2:0], sign_neg};
            sum  <= sum + add_term - sub_term;
        end
    end

endmodule

// File: rtl/signal_watchdog_mc.sv
// Multi-channel RX watchdog: per-stream sign-sum DC detection, SIGNAL length check,
// debounced trip FSM issuing a timed receiver_rst pulse followed by a hold-off.
module signal_watchdog_mc
    import signal_watchdog_pkg::*;
#(
    parameter int unsigned IQ_DATA_WIDTH  = 16,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned LOG2_SUM_LEN   = 6,
    parameter int unsigned MIN_SIGNAL_LEN = 14,
    parameter int unsigned RST_PULSE_LEN  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] iq_data,
    input  logic                              iq_valid,
    input  logic [NUM_CH-1:0]                 ch_mask,
    input  logic                              combine_all,
    input  logic [15:0]                       signal_len,
    input  logic                              sig_valid,
    input  logic [15:0]                       max_signal_len_th,
    input  logic [LOG2_SUM_LEN:0]             dc_running_sum_th,
    input  logic [7:0]                        debounce_th,
    input  logic [15:0]                       holdoff_len,
    output logic                              receiver_rst,
    output logic [1:0]                        trip_cause,
    output logic [NUM_CH-1:0]                 dc_flag,
    output logic                              window_full,
    output logic [15:0]                       trip_count
);

    localparam int unsigned W  = 1 << LOG2_SUM_LEN;
    localparam int unsigned SW = sum_width(LOG2_SUM_LEN);
    localparam int unsigned FW = LOG2_SUM_LEN + 1;
    localparam int unsigned NS = 2 * NUM_CH;
    localparam int unsigned PW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;

    wd_state_e             state;
    logic [FW-1:0]         fill;
    logic [7:0]            deb_cnt;
    logic [PW-1:0]         pulse_cnt;
    logic [15:0]           hold_cnt;
    logic signed [SW-1:0]  sums [NS];
    logic [NUM_CH-1:0]     hit;
    logic [7:0]            deb_th_eff;
    logic                  dc_cond;
    logic                  dc_trip;
    logic                  len_fault;
    logic                  trip;
    logic                  unused_iq_mag;

    // Only sign bits feed the detector; sample magnitudes are irrelevant.
    assign unused_iq_mag = ^iq_data;

    for (genvar s = 0; s < NS; s++) begin : g_stream
        sign_window_sum #(.LOG2_SUM_LEN(LOG2_SUM_LEN)) u_sum (
            .clk          (clk),
            .rst          (rst),
            .sample_valid (iq_valid),
            .sign_neg     (iq_data[s*IQ_DATA_WIDTH + IQ_DATA_WIDTH - 1]),
            .window_full  (window_full),
            .flush        (trip),
            .sum          (sums[s])
        );
    end

    function automatic logic mag_ge(input logic signed [SW-1:0] v, input logic [FW-1:0] th);
        logic [SW-1:0] mag;
        mag = v[SW-1] ? (~v + SW'(1)) : v;
        return mag >= SW'(th);
    endfunction

    always_comb begin
        hit = '0;
        for (int c = 0; c < NUM_CH; c++)
            hit[c] = window_full & (mag_ge(sums[2*c], dc_running_sum_th) |
                                    mag_ge(sums[2*c+1], dc_running_sum_th));
    end

    // Trip qualification; all inputs are sampled at the edge, outputs stay registered.
    always_comb begin
        deb_th_eff = (debounce_th == 8'd0) ? 8'd1 : debounce_th;
        dc_cond    = combine_all ? ((ch_mask != '0) && ((dc_flag & ch_mask) == ch_mask))
                                 : (|dc_flag);
        dc_trip    = iq_valid & dc_cond & (({1'b0, deb_cnt} + 9'd1) >= {1'b0, deb_th_eff});
        len_fault  = sig_valid & ((signal_len < 16'(MIN_SIGNAL_LEN)) |
                                  (signal_len > max_signal_len_th));
        trip       = enable & (state == ST_ARMED) & (len_fault | dc_trip);
    end

    // Shared fill counter; a trip flushes the window and discards a coincident sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill        <= '0;
            window_full <= 1'b0;
        end else if (trip) begin
            fill        <= '0;
            window_full <= 1'b0;
        end else if (iq_valid && !window_full) begin
            fill        <= fill + FW'(1);
            window_full <= (fill == FW'(W - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dc_flag <= '0;
        else
            dc_flag <= hit & ch_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_ARMED;
            deb_cnt      <= '0;
            pulse_cnt    <= '0;
            hold_cnt     <= '0;
            receiver_rst <= 1'b0;
            trip_cause   <= CAUSE_NONE;
            trip_count   <= '0;
        end else if (!enable) begin
            state        <= ST_ARMED;
            deb_cnt      <= '0;
            pulse_cnt    <= '0;
            hold_cnt     <= '0;
            receiver_rst <= 1'b0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (trip) begin
                        state        <= ST_FIRE;
                        receiver_rst <= 1'b1;
                        deb_cnt      <= '0;
                        pulse_cnt    <= '0;
                        trip_cause   <= (dc_trip ? CAUSE_DC : CAUSE_NONE) |
                                        (len_fault ? CAUSE_LEN : CAUSE_NONE);
                        if (trip_count != 16'hFFFF)
                            trip_count <= trip_count + 16'd1;
                    end else if (iq_valid) begin
                        deb_cnt <= dc_cond ? deb_cnt + 8'd1 : 8'd0;
                    end
                end
                ST_FIRE: begin
                    if (pulse_cnt == PW'(RST_PULSE_LEN - 1)) begin
                        state        <= ST_HOLDOFF;
                        receiver_rst <= 1'b0;
                        hold_cnt     <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt >= holdoff_len)
                        state <= ST_ARMED;
                    else
                        hold_cnt <= hold_cnt + 16'd1;
                end
                default: state <= ST_ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_signal_watchdog_mc.sv
// Directed self-checking bench for signal_watchdog_mc (NUM_CH=2, L=6, pulse 4).
module tb_signal_watchdog_mc;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [63:0] iq_data;
    logic        iq_valid;
    logic [1:0]  ch_mask;
    logic        combine_all;
    logic [15:0] signal_len;
    logic        sig_valid;
    logic [15:0] max_signal_len_th;
    logic [6:0]  dc_running_sum_th;
    logic [7:0]  debounce_th;
    logic [15:0] holdoff_len;
    logic        receiver_rst;
    logic [1:0]  trip_cause;
    logic [1:0]  dc_flag;
    logic        window_full;
    logic [15:0] trip_count;

    int vectors;
    int miscompares;
    int mode [4];   // per stream: 0 alternating, 1 constant +, 2 constant -
    logic phase;

    signal_watchdog_mc #(
        .IQ_DATA_WIDTH(16), .NUM_CH(2), .LOG2_SUM_LEN(6),
        .MIN_SIGNAL_LEN(14), .RST_PULSE_LEN(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .iq_data(iq_data), .iq_valid(iq_valid),
        .ch_mask(ch_mask), .combine_all(combine_all), .signal_len(signal_len),
        .sig_valid(sig_valid), .max_signal_len_th(max_signal_len_th),
        .dc_running_sum_th(dc_running_sum_th), .debounce_th(debounce_th),
        .holdoff_len(holdoff_len), .receiver_rst(receiver_rst), .trip_cause(trip_cause),
        .dc_flag(dc_flag), .window_full(window_full), .trip_count(trip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic build_iq();
        logic neg;
        for (int s = 0; s < 4; s++) begin
            neg = (mode[s] == 2) || (mode[s] == 0 && phase);
            iq_data[s*16 +: 16] = neg ? 16'hFF9C : 16'h0064;
        end
    endtask

    task automatic send_valid(input int n);
        for (int i = 0; i < n; i++) begin
            build_iq();
            iq_valid = 1'b1;
            tick();
            phase = ~phase;
        end
        iq_valid = 1'b0;
    endtask

    task automatic len_strobe(input logic [15:0] len);
        signal_len = len;
        sig_valid  = 1'b1;
        tick();
        sig_valid  = 1'b0;
    endtask

    task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
        phase = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; enable = 1'b1; iq_data = '0; iq_valid = 1'b0;
        ch_mask = 2'b11; combine_all = 1'b0; signal_len = 16'd100; sig_valid = 1'b0;
        max_signal_len_th = 16'd1000; dc_running_sum_th = 7'd40; debounce_th = 8'd1;
        holdoff_len = 16'd10;
        set_modes(1, 0, 0, 0);
        idle(3);
        chk("reset receiver_rst", receiver_rst, 0);
        chk("reset trip_cause", trip_cause, 0);
        chk("reset dc_flag", dc_flag, 0);
        chk("reset window_full", window_full, 0);
        chk("reset trip_count", trip_count, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Any-combining: ch0 I constant positive
        send_valid(63);
        chk("t1 not full at 63", window_full, 0);
        send_valid(1);
        chk("t1 full at 64", window_full, 1);
        chk("t1 flag lags sum", dc_flag, 2'b00);
        idle(1);
        chk("t1 dc_flag", dc_flag, 2'b01);
        chk("t1 no trip without valid", receiver_rst, 0);
        send_valid(1);
        chk("t1 rst rises", receiver_rst, 1);
        chk("t1 cause dc", trip_cause, 2'b01);
        chk("t1 count", trip_count, 1);
        chk("t1 window flushed", window_full, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1 rst held", receiver_rst, 1);
        end
        tick();
        chk("t1 rst after 4 cycles", receiver_rst, 0);
        idle(20);

        // All-combining: ch0 alone must not trip; ch1 Q constant negative completes it
        combine_all = 1'b1;
        set_modes(1, 0, 0, 0);
        send_valid(64);
        idle(1);
        chk("t2 dc_flag ch0 only", dc_flag, 2'b01);
        send_valid(1);
        chk("t2 no trip one channel", receiver_rst, 0);
        mode[3] = 2;
        send_valid(40);
        chk("t2 ch1 not yet flagged", dc_flag, 2'b01);
        chk("t2 no trip yet", receiver_rst, 0);
        send_valid(1);
        chk("t2 both flagged", dc_flag, 2'b11);
        chk("t2 trip waits for valid", receiver_rst, 0);
        send_valid(1);
        chk("t2 trip", receiver_rst, 1);
        chk("t2 cause", trip_cause, 2'b01);
        chk("t2 count", trip_count, 2);
        idle(20);

        // Debounce of 5 with an interrupting clean valid
        combine_all = 1'b0;
        debounce_th = 8'd5;
        dc_running_sum_th = 7'd127;
        set_modes(1, 0, 0, 0);
        send_valid(64);
        idle(1);
        chk("t3 no flag at high th", dc_flag, 2'b00);
        dc_running_sum_th = 7'd40;
        idle(1);
        chk("t3 flag", dc_flag, 2'b01);
        send_valid(4);
        chk("t3 4 hits no trip", receiver_rst, 0);
        dc_running_sum_th = 7'd127;
        idle(1);
        send_valid(1);
        chk("t3 clean valid", receiver_rst, 0);
        dc_running_sum_th = 7'd40;
        idle(1);
        send_valid(4);
        chk("t3 4 hits after clean", receiver_rst, 0);
        send_valid(1);
        chk("t3 5th hit trips", receiver_rst, 1);
        chk("t3 count", trip_count, 3);
        idle(20);

        // SIGNAL length boundaries
        dc_running_sum_th = 7'd127;
        len_strobe(16'd13);
        chk("t4 len 13 trips", receiver_rst, 1);
        chk("t4 cause len", trip_cause, 2'b10);
        chk("t4 count", trip_count, 4);
        idle(20);
        len_strobe(16'd14);
        chk("t4 len 14 legal", receiver_rst, 0);
        len_strobe(16'd1000);
        chk("t4 len max legal", receiver_rst, 0);
        chk("t4 cause held", trip_cause, 2'b10);
        len_strobe(16'd1001);
        chk("t4 len max+1 trips", receiver_rst, 1);
        chk("t4 count max+1", trip_count, 5);
        idle(20);

        // Hold-off of 100 cycles
        holdoff_len = 16'd100;
        len_strobe(16'd13);
        chk("t5 trip count", trip_count, 6);
        idle(54);
        len_strobe(16'd13);
        chk("t5 ignored mid holdoff", receiver_rst, 0);
        chk("t5 count held", trip_count, 6);
        idle(49);
        len_strobe(16'd13);
        chk("t5 ignored last holdoff cycle", receiver_rst, 0);
        len_strobe(16'd13);
        chk("t5 trips after holdoff", receiver_rst, 1);
        chk("t5 count", trip_count, 7);
        holdoff_len = 16'd2;
        idle(20);

        // Simultaneous DC and length trip
        debounce_th = 8'd1;
        dc_running_sum_th = 7'd40;
        set_modes(1, 0, 0, 0);
        send_valid(64);
        idle(1);
        signal_len = 16'd13;
        sig_valid = 1'b1;
        send_valid(1);
        sig_valid = 1'b0;
        chk("t6 both trip", receiver_rst, 1);
        chk("t6 cause both", trip_cause, 2'b11);
        chk("t6 count", trip_count, 8);

        // Async reset mid-FIRE
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t7 async rst drops", receiver_rst, 0);
        chk("t7 rst count", trip_count, 0);
        chk("t7 rst cause", trip_cause, 0);
        chk("t7 rst dc_flag", dc_flag, 0);
        chk("t7 rst window_full", window_full, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // enable=0 mid-holdoff returns to ARMED with counters held
        holdoff_len = 16'd100;
        len_strobe(16'd13);
        chk("t8 trip", trip_count, 1);
        idle(10);
        enable = 1'b0;
        tick();
        chk("t8 disabled rst low", receiver_rst, 0);
        chk("t8 count held", trip_count, 1);
        chk("t8 cause held", trip_cause, 2'b10);
        enable = 1'b1;
        len_strobe(16'd13);
        chk("t8 armed again", receiver_rst, 1);
        chk("t8 count", trip_count, 2);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
